// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that lets two cache controllers share one main-memory line port.
// Only one transaction is outstanding at a time, and every output is registered.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int LINE_W         = 128,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_mem_read,
  input  logic              c0_mem_write,
  input  logic [ADDR_W-1:0] c0_m_addr,
  input  logic [LINE_W-1:0] c0_m_w_data,
  output logic [LINE_W-1:0] c0_m_r_data,
  output logic              c0_ack,
  input  logic              c1_mem_read,
  input  logic              c1_mem_write,
  input  logic [ADDR_W-1:0] c1_m_addr,
  input  logic [LINE_W-1:0] c1_m_w_data,
  output logic [LINE_W-1:0] c1_m_r_data,
  output logic              c1_ack,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_w_data,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [LINE_W-1:0] m_r_data,
  input  logic              main_mem_ack,
  output logic              grant,
  output logic              busy,
  output logic              timeout_err
);

  // state | meaning
  // IDLE  | sample requests and grant one
  // BUSY  | strobe held, waiting for main_mem_ack or watchdog expiry
  // DONE  | ack cycle; requests ignored so the winner can drop its level
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int WD_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state_q;
  logic              last_q;
  logic [WD_W-1:0]   wd_q;
  logic [ADDR_W-1:0] m_addr_q;
  logic [LINE_W-1:0] m_w_data_q;
  logic [LINE_W-1:0] c0_r_data_q;
  logic [LINE_W-1:0] c1_r_data_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              c0_ack_q;
  logic              c1_ack_q;
  logic              grant_q;
  logic              busy_q;
  logic              timeout_err_q;

  logic pend0;
  logic pend1;
  logic sel_d;
  logic sel_wr_d;
  logic wd_expired;

  assign pend0      = c0_mem_read | c0_mem_write;
  assign pend1      = c1_mem_read | c1_mem_write;
  // On a tie the requester that was not served last wins.
  assign sel_d      = (pend0 & pend1) ? ~last_q : pend1;
  assign sel_wr_d   = sel_d ? c1_mem_write : c0_mem_write;
  assign wd_expired = WD_EN && (wd_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      last_q        <= 1'b1;
      wd_q          <= '0;
      m_addr_q      <= '0;
      m_w_data_q    <= '0;
      c0_r_data_q   <= '0;
      c1_r_data_q   <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      c0_ack_q      <= 1'b0;
      c1_ack_q      <= 1'b0;
      grant_q       <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      c0_ack_q <= 1'b0;
      c1_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend0 | pend1) begin
            grant_q     <= sel_d;
            m_addr_q    <= sel_d ? c1_m_addr : c0_m_addr;
            m_w_data_q  <= sel_d ? c1_m_w_data : c0_m_w_data;
            mem_write_q <= sel_wr_d;
            mem_read_q  <= ~sel_wr_d;
            busy_q      <= 1'b1;
            wd_q        <= '0;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          if (main_mem_ack | wd_expired) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
            last_q      <= grant_q;
            state_q     <= DONE;
            if (grant_q) c1_ack_q <= 1'b1;
            else         c0_ack_q <= 1'b1;
            // A real ack wins over a watchdog expiry landing on the same edge.
            if (!main_mem_ack) begin
              timeout_err_q <= 1'b1;
              if (grant_q) c1_r_data_q <= '0;
              else         c0_r_data_q <= '0;
            end else if (mem_read_q) begin
              if (grant_q) c1_r_data_q <= m_r_data;
              else         c0_r_data_q <= m_r_data;
            end
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign c0_m_r_data = c0_r_data_q;
  assign c1_m_r_data = c1_r_data_q;
  assign c0_ack      = c0_ack_q;
  assign c1_ack      = c1_ack_q;
  assign m_addr      = m_addr_q;
  assign m_w_data    = m_w_data_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign grant       = grant_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int LINE_W = 128;
  localparam int TO     = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              c0_mem_read = 1'b0, c0_mem_write = 1'b0;
  logic [ADDR_W-1:0] c0_m_addr = '0;
  logic [LINE_W-1:0] c0_m_w_data = '0;
  logic [LINE_W-1:0] c0_m_r_data;
  logic              c0_ack;
  logic              c1_mem_read = 1'b0, c1_mem_write = 1'b0;
  logic [ADDR_W-1:0] c1_m_addr = '0;
  logic [LINE_W-1:0] c1_m_w_data = '0;
  logic [LINE_W-1:0] c1_m_r_data;
  logic              c1_ack;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_w_data;
  logic              mem_read, mem_write;
  logic [LINE_W-1:0] m_r_data = '0;
  logic              main_mem_ack = 1'b0;
  logic              grant, busy, timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .c0_mem_read(c0_mem_read), .c0_mem_write(c0_mem_write), .c0_m_addr(c0_m_addr),
    .c0_m_w_data(c0_m_w_data), .c0_m_r_data(c0_m_r_data), .c0_ack(c0_ack),
    .c1_mem_read(c1_mem_read), .c1_mem_write(c1_mem_write), .c1_m_addr(c1_m_addr),
    .c1_m_w_data(c1_m_w_data), .c1_m_r_data(c1_m_r_data), .c1_ack(c1_ack),
    .m_addr(m_addr), .m_w_data(m_w_data), .mem_read(mem_read), .mem_write(mem_write),
    .m_r_data(m_r_data), .main_mem_ack(main_mem_ack),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks the current owner, how long it has waited and a one-cycle cooldown.
  int                owner;
  bit                own_wr;
  int                waited;
  bit                cooldown;
  int                last_served;
  logic [LINE_W-1:0] e_rdat [2];
  bit                e_ack [2];
  logic [ADDR_W-1:0] e_addr;
  logic [LINE_W-1:0] e_wdata;
  bit                e_terr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner = -1; own_wr = 0; waited = 0; cooldown = 0; last_served = 1;
      e_rdat[0] = '0; e_rdat[1] = '0; e_ack[0] = 0; e_ack[1] = 0;
      e_addr = '0; e_wdata = '0; e_terr = 0;
    end else begin
      e_ack[0] = 0; e_ack[1] = 0;
      if (cooldown) begin
        cooldown = 0;
      end else if (owner >= 0) begin
        if (main_mem_ack || waited + 1 >= TO) begin
          if (!main_mem_ack) begin
            e_terr = 1;
            e_rdat[owner] = '0;
          end else if (!own_wr) begin
            e_rdat[owner] = m_r_data;
          end
          e_ack[owner] = 1;
          last_served = owner;
          owner = -1;
          cooldown = 1;
        end else begin
          waited++;
        end
      end else begin
        bit p0, p1;
        p0 = c0_mem_read | c0_mem_write;
        p1 = c1_mem_read | c1_mem_write;
        if (p0 || p1) begin
          if (p0 && p1) owner = 1 - last_served;
          else          owner = p1 ? 1 : 0;
          own_wr  = (owner == 1) ? c1_mem_write : c0_mem_write;
          e_addr  = (owner == 1) ? c1_m_addr : c0_m_addr;
          e_wdata = (owner == 1) ? c1_m_w_data : c0_m_w_data;
          waited  = 0;
        end
      end
    end
  end

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      check("busy", LINE_W'(busy), LINE_W'(owner >= 0));
      check("mem_read", LINE_W'(mem_read), LINE_W'(owner >= 0 && !own_wr));
      check("mem_write", LINE_W'(mem_write), LINE_W'(owner >= 0 && own_wr));
      check("c0_ack", LINE_W'(c0_ack), LINE_W'(e_ack[0]));
      check("c1_ack", LINE_W'(c1_ack), LINE_W'(e_ack[1]));
      check("c0_m_r_data", c0_m_r_data, e_rdat[0]);
      check("c1_m_r_data", c1_m_r_data, e_rdat[1]);
      check("timeout_err", LINE_W'(timeout_err), LINE_W'(e_terr));
      if (owner >= 0) begin
        check("grant", LINE_W'(grant), LINE_W'(owner));
        check("m_addr", LINE_W'(m_addr), LINE_W'(e_addr));
        check("m_w_data", m_w_data, e_wdata);
      end else begin
        check("grant_last", LINE_W'(grant), LINE_W'(last_served == 1 && (e_ack[1] || cooldown || grant)));
      end
    end
  end

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    c0_mem_read = 0; c0_mem_write = 0; c1_mem_read = 0; c1_mem_write = 0;
    main_mem_ack = 0; m_r_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  logic [LINE_W-1:0] pat_a5, pat_11, pat_de;
  int                gseq [6];
  int                gcount, cnt;
  bit                prev_busy, got_it;
  bit                act [2];
  int                ack_pct;

  initial begin
    pat_a5 = {16{8'hA5}};
    pat_11 = {16{8'h11}};
    pat_de = {4{32'hDEADBEEF}};

    // Reset state
    clear_inputs();
    step(); step();
    check("rst_mem_read", LINE_W'(mem_read), '0);
    check("rst_busy", LINE_W'(busy), '0);
    check("rst_grant", LINE_W'(grant), '0);
    rst_n = 1;

    // T1: c0 read, memory acks three cycles after the strobe
    step();
    c0_mem_read = 1; c0_m_addr = 32'h0000_1230;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_mem_read", LINE_W'(mem_read), LINE_W'(1));
      check("t1_m_addr", LINE_W'(m_addr), LINE_W'(32'h1230));
    end
    main_mem_ack = 1; m_r_data = pat_a5;
    step();
    main_mem_ack = 0; m_r_data = '0; c0_mem_read = 0;
    check("t1_c0_ack", LINE_W'(c0_ack), LINE_W'(1));
    check("t1_c0_rdata", c0_m_r_data, pat_a5);
    check("t1_c1_ack", LINE_W'(c1_ack), '0);
    check("t1_c1_rdata", c1_m_r_data, '0);
    check("t1_strobe_off", LINE_W'(mem_read), '0);
    step();
    check("t1_ack_pulse", LINE_W'(c0_ack), '0);

    // T2: simultaneous first requests after reset, c0 wins
    do_reset();
    c0_mem_read = 1; c0_m_addr = 32'h3000;
    c1_mem_write = 1; c1_m_addr = 32'h2000; c1_m_w_data = pat_11;
    step();
    check("t2_first_grant", LINE_W'(grant), '0);
    check("t2_first_read", LINE_W'(mem_read), LINE_W'(1));
    main_mem_ack = 1; m_r_data = pat_de;
    step();
    main_mem_ack = 0; c0_mem_read = 0;
    check("t2_c0_ack", LINE_W'(c0_ack), LINE_W'(1));
    step();
    check("t2_gap", LINE_W'(mem_write), '0);
    step();
    check("t2_c1_write", LINE_W'(mem_write), LINE_W'(1));
    check("t2_c1_grant", LINE_W'(grant), LINE_W'(1));
    check("t2_wdata", m_w_data, pat_11);
    check("t2_addr", LINE_W'(m_addr), LINE_W'(32'h2000));
    main_mem_ack = 1;
    step();
    main_mem_ack = 0; c1_mem_write = 0;
    check("t2_c1_ack", LINE_W'(c1_ack), LINE_W'(1));
    check("t2_c1_rdata_kept", c1_m_r_data, '0);
    step();

    // T3: both hold requests, grants must alternate starting with c0
    do_reset();
    c0_mem_read = 1; c0_m_addr = 32'h100; c1_mem_read = 1; c1_m_addr = 32'h200;
    gcount = 0; prev_busy = 0;
    for (int i = 0; i < 60 && gcount < 6; i++) begin
      step();
      if (busy && !prev_busy) begin
        gseq[gcount] = int'(grant);
        gcount++;
      end
      prev_busy = busy;
      main_mem_ack = mem_read | mem_write;
    end
    check("t3_grant_count", LINE_W'(gcount), LINE_W'(6));
    for (int k = 0; k < 6; k++) check("t3_grant_seq", LINE_W'(gseq[k]), LINE_W'(k % 2));
    c0_mem_read = 0; c1_mem_read = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      main_mem_ack = mem_read | mem_write;
    end
    main_mem_ack = 0;
    step();

    // T4: watchdog abort on a c1 read with no memory ack
    do_reset();
    c1_mem_read = 1; c1_m_addr = 32'h6000;
    step();
    main_mem_ack = 1; m_r_data = pat_de;
    step();
    main_mem_ack = 0; c1_mem_read = 0;
    check("t4_pre_rdata", c1_m_r_data, pat_de);
    step(); step();
    c1_mem_read = 1;
    cnt = 0; got_it = 0;
    for (int i = 0; i < 40 && !got_it; i++) begin
      step();
      if (mem_read) cnt++;
      if (c1_ack) got_it = 1;
    end
    c1_mem_read = 0;
    check("t4_ack_seen", LINE_W'(got_it), LINE_W'(1));
    check("t4_busy_cycles", LINE_W'(cnt), LINE_W'(TO));
    check("t4_rdata_zero", c1_m_r_data, '0);
    check("t4_terr", LINE_W'(timeout_err), LINE_W'(1));
    step(); step(); step();
    check("t4_terr_sticky", LINE_W'(timeout_err), LINE_W'(1));

    // T5: reset in the middle of a c0 write, then a clean c1 read
    do_reset();
    check("t5_terr_cleared", LINE_W'(timeout_err), '0);
    c0_mem_write = 1; c0_m_addr = 32'h4000; c0_m_w_data = pat_11;
    step(); step();
    check("t5_write_active", LINE_W'(mem_write), LINE_W'(1));
    #2 rst_n = 0;
    #1;
    check("t5_async_write", LINE_W'(mem_write), '0);
    check("t5_async_busy", LINE_W'(busy), '0);
    check("t5_async_grant", LINE_W'(grant), '0);
    c0_mem_write = 0;
    step();
    rst_n = 1;
    c1_mem_read = 1; c1_m_addr = 32'h5000;
    got_it = 0;
    for (int i = 0; i < 20 && !got_it; i++) begin
      step();
      if (c1_ack) got_it = 1;
      main_mem_ack = mem_read;
      m_r_data = pat_a5;
    end
    main_mem_ack = 0; c1_mem_read = 0;
    check("t5_c1_served", LINE_W'(got_it), LINE_W'(1));
    check("t5_c1_rdata", c1_m_r_data, pat_a5);
    check("t5_c1_grant", LINE_W'(grant), LINE_W'(1));
    step();

    // T6: spurious acks while idle, then read+write issues a write only
    main_mem_ack = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_spurious_c0", LINE_W'(c0_ack), '0);
      check("t6_spurious_c1", LINE_W'(c1_ack), '0);
    end
    main_mem_ack = 0;
    c0_mem_read = 1; c0_mem_write = 1; c0_m_addr = 32'h7000; c0_m_w_data = pat_de;
    step();
    check("t6_rw_write", LINE_W'(mem_write), LINE_W'(1));
    check("t6_rw_noread", LINE_W'(mem_read), '0);
    main_mem_ack = 1;
    step();
    c0_mem_read = 0; c0_mem_write = 0;
    step();
    main_mem_ack = 0;
    step();

    // Randomized traffic, including stretches without any memory ack
    act[0] = 0; act[1] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      ack_pct = ((cyc % 400) < 40) ? 0 : 35;
      main_mem_ack = ($urandom_range(0, 99) < ack_pct);
      m_r_data = rnd_line();
      if (act[0] && c0_ack) begin act[0] = 0; c0_mem_read = 0; c0_mem_write = 0; end
      if (act[1] && c1_ack) begin act[1] = 0; c1_mem_read = 0; c1_mem_write = 0; end
      if (!act[0] && $urandom_range(0, 99) < 25) begin
        int k;
        k = $urandom_range(0, 2);
        act[0] = 1;
        c0_mem_read = (k != 1); c0_mem_write = (k != 0);
        c0_m_addr = $urandom; c0_m_w_data = rnd_line();
      end
      if (!act[1] && $urandom_range(0, 99) < 25) begin
        int k;
        k = $urandom_range(0, 2);
        act[1] = 1;
        c1_mem_read = (k != 1); c1_mem_write = (k != 0);
        c1_m_addr = $urandom; c1_m_w_data = rnd_line();
      end
    end
    clear_inputs();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
